// File: rtl/xbus_router_pkg.sv
// -----------------------------------------------------------------------------
// xbus_router_pkg
// Shared definitions for the system bus router:
//   - FSM state encoding used by xbus_router
//   - default address / data widths
//   - base/mask constants of the standard slave windows (MEM, REGF, CPRT, EXT,
//     LED0, SW, BTN3) and packed default tables built from them, for use when
//     the router is instantiated in the system top
//   - width helper functions shared by the top and the address matcher
// No ports (package).
// -----------------------------------------------------------------------------
package xbus_router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } xstate_e;

   localparam int XB_ADDR_W = 12;
   localparam int XB_DATA_W = 32;

   // Standard slave windows; a set mask bit means that address bit is compared.
   localparam logic [11:0] MEM_BASE  = 12'h000;
   localparam logic [11:0] MEM_MASK  = 12'hC00;
   localparam logic [11:0] REGF_BASE = 12'h400;
   localparam logic [11:0] REGF_MASK = 12'hF00;
   localparam logic [11:0] CPRT_BASE = 12'h500;
   localparam logic [11:0] CPRT_MASK = 12'hFF0;
   localparam logic [11:0] EXT_BASE  = 12'h800;
   localparam logic [11:0] EXT_MASK  = 12'h800;
   localparam logic [11:0] LED0_BASE = 12'h600;
   localparam logic [11:0] LED0_MASK = 12'hFFF;
   localparam logic [11:0] SW_BASE   = 12'h604;
   localparam logic [11:0] SW_MASK   = 12'hFFF;
   localparam logic [11:0] BTN3_BASE = 12'h608;
   localparam logic [11:0] BTN3_MASK = 12'hFFF;

   // Packed tables for a 7-slave system map, slave 0 in the low bits.
   localparam int XB_STD_N_SLV = 7;
   localparam logic [7*12-1:0] XB_STD_BASE = {BTN3_BASE, SW_BASE, LED0_BASE,
      EXT_BASE, CPRT_BASE, REGF_BASE, MEM_BASE};
   localparam logic [7*12-1:0] XB_STD_MASK = {BTN3_MASK, SW_MASK, LED0_MASK,
      EXT_MASK, CPRT_MASK, REGF_MASK, MEM_MASK};

   // Index width for n slaves; never zero so a single-slave build still has a bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Timeout counter width; kept at one bit when the timeout is disabled.
   function automatic int cnt_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/xbus_router_xaddr_match.sv
// -----------------------------------------------------------------------------
// xaddr_match
// Combinational address decoder: compares addr against N_SLV base/mask windows
// and reports whether any window hit plus the lowest hitting index.
// Ports:
//   addr     in  ADDR_W  address to decode
//   hit      out 1       at least one window matches
//   hit_idx  out IDX_W   lowest matching window index (0 when no hit)
// -----------------------------------------------------------------------------
module xaddr_match
   import xbus_router_pkg::*;
#(
   parameter int                        ADDR_W   = XB_ADDR_W,
   parameter int                        N_SLV    = 8,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0,
   parameter int                        IDX_W    = idx_width(N_SLV)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [IDX_W-1:0]  hit_idx
);

   logic [N_SLV-1:0] match_s;

   // Per-window masked compare.
   always_comb begin
      match_s = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
             (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
            match_s[i] = 1'b1;
         end else begin
            match_s[i] = 1'b0;
         end
      end
   end

   // Priority encode: scan from the top down so the lowest index is written last.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (match_s[i]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end else begin
            hit     = hit;
            hit_idx = hit_idx;
         end
      end
   end

endmodule

// File: rtl/xbus_router.sv
// -----------------------------------------------------------------------------
// xbus_router
// CPU data-bus router: decodes the request address against N_SLV windows,
// drives a one-hot slave select, waits for the selected slave's completion with
// an optional no-response timeout, and returns a one-cycle ready pulse with the
// captured read data. Misses and timeouts raise a trap pulse and a sticky error
// holding the first failing address.
// Ports:
//   clk         in  1             system clock
//   rst         in  1             synchronous active-high reset
//   addr        in  ADDR_W        request address, held until ready
//   sel         in  1             request strobe, held until ready
//   ready       out 1             one-cycle completion pulse
//   data_to_rd  out DATA_W        captured read data, valid while ready=1
//   slv_sel     out N_SLV         one-hot slave select
//   slv_ready   in  N_SLV         per-slave completion
//   slv_rdata   in  N_SLV*DATA_W  packed per-slave read data
//   trap_sel    out 1             one-cycle pulse on miss or timeout
//   err_valid   out 1             sticky error flag
//   err_addr    out ADDR_W        address of first unacknowledged error
//   err_clr     in  1             clears err_valid (a new error wins)
// -----------------------------------------------------------------------------
module xbus_router
   import xbus_router_pkg::*;
#(
   parameter int                        ADDR_W   = XB_ADDR_W,
   parameter int                        DATA_W   = XB_DATA_W,
   parameter int                        N_SLV    = 8,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
   parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0,
   parameter int                        TIMEOUT  = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         addr,
   input  logic                      sel,
   output logic                      ready,
   output logic [DATA_W-1:0]         data_to_rd,
   output logic [N_SLV-1:0]          slv_sel,
   input  logic [N_SLV-1:0]          slv_ready,
   input  logic [N_SLV*DATA_W-1:0]   slv_rdata,
   output logic                      trap_sel,
   output logic                      err_valid,
   output logic [ADDR_W-1:0]         err_addr,
   input  logic                      err_clr
);

   localparam int                 IDX_W   = idx_width(N_SLV);
   localparam int                 CNT_W   = cnt_width(TIMEOUT);
   localparam logic               TO_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0]   TO_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   xstate_e            state_r;
   xstate_e            next_state_s;
   logic [IDX_W-1:0]   idx_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [ADDR_W-1:0]  req_addr_r;

   logic               hit_s;
   logic [IDX_W-1:0]   hit_idx_s;
   logic               sel_ready_s;
   logic [DATA_W-1:0]  sel_rdata_s;
   logic               timeout_s;
   logic [IDX_W-1:0]   sel_idx_s;
   logic [N_SLV-1:0]   slv_sel_nxt_s;
   logic               err_set_s;
   logic [ADDR_W-1:0]  err_addr_nxt_s;

   xaddr_match #(
      .ADDR_W   (ADDR_W),
      .N_SLV    (N_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK),
      .IDX_W    (IDX_W)
   ) u_match (
      .addr    (addr),
      .hit     (hit_s),
      .hit_idx (hit_idx_s)
   );

   // Selected-slave completion and read data; other slaves' ready bits never reach the FSM.
   always_comb begin
      sel_ready_s = slv_ready[idx_r];
      sel_rdata_s = slv_rdata[idx_r*DATA_W +: DATA_W];
   end

   // Timeout fires in the WAIT cycle whose counter reaches TIMEOUT-1.
   always_comb begin
      if (TO_EN && (cnt_r == TO_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Next-state logic; a ready in the last timeout cycle takes priority over the timeout.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (sel) begin
               if (hit_s) begin
                  next_state_s = ST_WAIT;
               end else begin
                  next_state_s = ST_ERR;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (sel_ready_s) begin
               next_state_s = ST_DONE;
            end else if (timeout_s) begin
               next_state_s = ST_ERR;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DONE: next_state_s = ST_IDLE;
         ST_ERR:  next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Next slave select: one-hot of the index that will be held in WAIT, else all low.
   always_comb begin
      slv_sel_nxt_s = '0;
      if (state_r == ST_IDLE) begin
         sel_idx_s = hit_idx_s;
      end else begin
         sel_idx_s = idx_r;
      end
      if (next_state_s == ST_WAIT) begin
         slv_sel_nxt_s[sel_idx_s] = 1'b1;
      end else begin
         slv_sel_nxt_s = '0;
      end
   end

   // Error capture: a miss reports the live address, a timeout the latched one.
   always_comb begin
      err_set_s = (next_state_s == ST_ERR) ? 1'b1 : 1'b0;
      if (state_r == ST_IDLE) begin
         err_addr_nxt_s = addr;
      end else begin
         err_addr_nxt_s = req_addr_r;
      end
   end

   // State, index, counter and request address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         idx_r      <= '0;
         cnt_r      <= '0;
         req_addr_r <= '0;
      end else begin
         state_r <= next_state_s;
         if ((state_r == ST_IDLE) && sel) begin
            idx_r      <= hit_idx_s;
            req_addr_r <= addr;
         end
         // Cleared on WAIT entry, saturates instead of wrapping.
         if ((state_r != ST_WAIT) && (next_state_s == ST_WAIT)) begin
            cnt_r <= '0;
         end else if ((state_r == ST_WAIT) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Registered handshake outputs, slave select and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready      <= 1'b0;
         trap_sel   <= 1'b0;
         slv_sel    <= '0;
         data_to_rd <= '0;
      end else begin
         ready    <= ((next_state_s == ST_DONE) || (next_state_s == ST_ERR)) ? 1'b1 : 1'b0;
         trap_sel <= (next_state_s == ST_ERR) ? 1'b1 : 1'b0;
         slv_sel  <= slv_sel_nxt_s;
         if (next_state_s == ST_DONE) begin
            data_to_rd <= sel_rdata_s;
         end else if (next_state_s == ST_ERR) begin
            data_to_rd <= '0;
         end
      end
   end

   // Sticky error flag and first-error address; set beats clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
      end else begin
         if (err_set_s) begin
            err_valid <= 1'b1;
         end else if (err_clr) begin
            err_valid <= 1'b0;
         end
         if (err_set_s && !err_valid) begin
            err_addr <= err_addr_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_xbus_router.sv
// -----------------------------------------------------------------------------
// tb_xbus_router
// Directed scoreboard bench for xbus_router: requests push their expected
// response, a negedge monitor pops and compares on every ready pulse.
// -----------------------------------------------------------------------------
module tb_xbus_router;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NS = 8;
   localparam int TO = 15;

   // Windows: 0 000/F00, 1 200/F00, 2 300/F00, 3 240/FF0 (overlaps 1),
   // 4 400/F00 (never ready), 5 500/F00, 6 600/F00, 7 700/FF0.
   localparam logic [NS*AW-1:0] BASES = {12'h700, 12'h600, 12'h500, 12'h400,
                                         12'h240, 12'h300, 12'h200, 12'h000};
   localparam logic [NS*AW-1:0] MASKS = {12'hFF0, 12'hF00, 12'hF00, 12'hF00,
                                         12'hFF0, 12'hF00, 12'hF00, 12'hF00};

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [AW-1:0]     addr = '0;
   logic              sel = 1'b0;
   logic              ready;
   logic [DW-1:0]     data_to_rd;
   logic [NS-1:0]     slv_sel;
   logic [NS-1:0]     slv_ready;
   logic [NS*DW-1:0]  slv_rdata;
   logic              trap_sel;
   logic              err_valid;
   logic [AW-1:0]     err_addr;
   logic              err_clr = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int wcnt   = 0;
   logic t3   = 1'b0;

   typedef struct {
      logic [DW-1:0] data;
      logic          trap;
      logic          ev;
      logic [AW-1:0] ea;
      int            cyc;
   } exp_t;
   exp_t exp_q[$];

   xbus_router #(
      .ADDR_W(AW), .DATA_W(DW), .N_SLV(NS),
      .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .sel(sel), .ready(ready),
      .data_to_rd(data_to_rd), .slv_sel(slv_sel), .slv_ready(slv_ready),
      .slv_rdata(slv_rdata), .trap_sel(trap_sel), .err_valid(err_valid),
      .err_addr(err_addr), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Cycle counter, cycles-selected counter and slave 3 toggle.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      wcnt <= (slv_sel != '0) ? wcnt + 1 : 0;
      t3   <= ~t3;
   end

   // Slave models: 0,5,6,7 always ready; 1 after 2 selected cycles; 2 after 4;
   // 3 toggles regardless of select; 4 never answers.
   always_comb begin
      slv_rdata = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                   32'h33333333, 32'hCAFE0002, 32'h11111111, 32'hDEADBEEF};
      slv_ready    = 8'b1110_0001;
      slv_ready[1] = (slv_sel[1] && (wcnt == 2)) ? 1'b1 : 1'b0;
      slv_ready[2] = (slv_sel[2] && (wcnt == 4)) ? 1'b1 : 1'b0;
      slv_ready[3] = t3;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ready pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready_cycle", 64'(cyc), 64'(e.cyc));
            chk("data_to_rd", 64'(data_to_rd), 64'(e.data));
            chk("trap_sel", 64'(trap_sel), 64'(e.trap));
            chk("err_valid", 64'(err_valid), 64'(e.ev));
            chk("err_addr", 64'(err_addr), 64'(e.ea));
            chk("slv_sel_on_ready", 64'(slv_sel), 64'd0);
         end
      end
   end

   // One request: issue in an idle cycle, check select at cycle 1, wait for ready.
   task automatic req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic tr,
                      input logic ev, input logic [AW-1:0] ea, input int lat,
                      input logic clr, input logic [NS-1:0] sel1);
      exp_t e;
      bit   got;
      @(negedge clk);
      addr    = a;
      sel     = 1'b1;
      err_clr = clr;
      e.data = d; e.trap = tr; e.ev = ev; e.ea = ea; e.cyc = cyc + lat;
      exp_q.push_back(e);
      @(negedge clk);
      err_clr = 1'b0;
      chk("slv_sel_cycle1", 64'(slv_sel), 64'(sel1));
      got = ready;
      for (int k = 0; (k < 40) && !got; k++) begin
         @(negedge clk);
         got = ready;
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout: got no ready expected ready for addr 0x%0h", a);
         exp_q.delete();
      end
      sel = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_trap", 64'(trap_sel), 64'd0);
      chk("rst_slv_sel", 64'(slv_sel), 64'd0);
      chk("rst_data", 64'(data_to_rd), 64'd0);
      chk("rst_err_valid", 64'(err_valid), 64'd0);
      chk("rst_err_addr", 64'(err_addr), 64'd0);
      rst = 1'b0;

      // Hits: zero-wait, 4 wait states, overlapping windows, back-to-back
      req(12'h012, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 2, 1'b0, 8'h01);
      req(12'h345, 32'hCAFE0002, 1'b0, 1'b0, 12'h000, 6, 1'b0, 8'h04);
      req(12'h240, 32'h11111111, 1'b0, 1'b0, 12'h000, 4, 1'b0, 8'h02);
      req(12'h0A0, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 2, 1'b0, 8'h01);
      req(12'h5FF, 32'h55555555, 1'b0, 1'b0, 12'h000, 2, 1'b0, 8'h20);

      // Timeout on the silent slave
      req(12'h412, 32'h0, 1'b1, 1'b1, 12'h412, 16, 1'b0, 8'h10);

      // Lone clear drops the flag but keeps the address
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_err_valid", 64'(err_valid), 64'd0);
      chk("clr_err_addr", 64'(err_addr), 64'h412);

      // Misses: first address captured, later ones don't overwrite, set beats clear
      req(12'h800, 32'h0, 1'b1, 1'b1, 12'h800, 1, 1'b0, 8'h00);
      req(12'h9AB, 32'h0, 1'b1, 1'b1, 12'h800, 1, 1'b0, 8'h00);
      req(12'hC00, 32'h0, 1'b1, 1'b1, 12'h800, 1, 1'b1, 8'h00);
      @(negedge clk);
      chk("set_wins_err_valid", 64'(err_valid), 64'd1);
      req(12'h705, 32'h77777777, 1'b0, 1'b1, 12'h800, 2, 1'b0, 8'h80);

      // Reset in cycle 2 of a WAIT: everything clears, no ready follows
      @(negedge clk);
      addr = 12'h300;
      sel  = 1'b1;
      @(negedge clk);
      chk("rstw_slv_sel_cycle1", 64'(slv_sel), 64'h04);
      @(negedge clk);
      rst = 1'b1;
      sel = 1'b0;
      @(negedge clk);
      chk("rstw_ready", 64'(ready), 64'd0);
      chk("rstw_trap", 64'(trap_sel), 64'd0);
      chk("rstw_slv_sel", 64'(slv_sel), 64'd0);
      chk("rstw_data", 64'(data_to_rd), 64'd0);
      chk("rstw_err_valid", 64'(err_valid), 64'd0);
      chk("rstw_err_addr", 64'(err_addr), 64'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Fresh request after reset
      req(12'h012, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 2, 1'b0, 8'h01);
      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
